// File: rtl/nios2os_vjtag_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG host link.
// Holds the scan-state encoding, default widths and the debug IR codes.
package nios2os_vjtag_pkg;

   localparam int DEF_DR_WIDTH = 38;
   localparam int DEF_IR_WIDTH = 2;

   localparam logic [DEF_IR_WIDTH-1:0] IR_OCIMEM    = 2'b00;
   localparam logic [DEF_IR_WIDTH-1:0] IR_TRACEMEM  = 2'b01;
   localparam logic [DEF_IR_WIDTH-1:0] IR_BREAK     = 2'b10;
   localparam logic [DEF_IR_WIDTH-1:0] IR_TRACECTRL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_UIR  = 3'd1,
      ST_CDR  = 3'd2,
      ST_SDR  = 3'd3,
      ST_UDR  = 3'd4,
      ST_RTI  = 3'd5
   } vjtag_state_e;

endpackage

// File: rtl/nios2os_vjtag_host_tckgen.sv
// Virtual TCK generator: divides clk by 2*TCK_DIV while enabled and flags
// the clk cycle on which tck is about to rise or fall.
module nios2os_vjtag_host_tckgen
   import nios2os_vjtag_pkg::*;
#(
   parameter int TCK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_en,
   output logic o_tck,
   output logic o_rise,
   output logic o_fall
);

   localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_tck;
   logic          w_term;

   assign w_term = i_en && (r_cnt == CW'(TCK_DIV - 1));
   assign o_rise = w_term & ~r_tck;
   assign o_fall = w_term & r_tck;
   assign o_tck  = r_tck;

   // Disable parks tck low so every scan state starts on a low phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else if (w_term) begin
         r_cnt <= '0;
         r_tck <= ~r_tck;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/nios2os_vjtag_host.sv
// Host end of the Nios II virtual-JTAG debug link: runs IR/DR scans and captures tdo.
// Optional capture comparison is enabled by defining NIOS2OS_VJTAG_HOST_CHECK_EN.
module nios2os_vjtag_host
   import nios2os_vjtag_pkg::*;
#(
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int TCK_DIV  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   input  logic                cmd_ir_only,
   output logic                rsp_valid,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                busy,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti,
`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
   input  logic [DR_WIDTH-1:0] cmd_expect,
   input  logic [DR_WIDTH-1:0] cmd_mask,
   output logic                rsp_mismatch,
`endif
   output vjtag_state_e        o_dbg_state
);

   localparam int BW = $clog2(DR_WIDTH + 1);

   vjtag_state_e        r_state;
   vjtag_state_e        w_state_nxt;
   logic                w_tck_en;
   logic                w_rise;
   logic                w_fall;
   logic                w_accept;
   logic                w_done;
   logic                w_sdr_rise;
   logic [DR_WIDTH-1:0] w_shift_nxt;

   logic                r_cmd_ready;
   logic                r_busy;
   logic                r_rsp_valid;
   logic [DR_WIDTH-1:0] r_rsp_dr;
   logic [DR_WIDTH-1:0] r_shift;
   logic [BW-1:0]       r_bitcnt;
   logic                r_ir_only;
   logic [IR_WIDTH-1:0] r_ir;
   logic                r_tdi;
   logic                r_uir;
   logic                r_cdr;
   logic                r_sdr;
   logic                r_udr;
   logic                r_rti;

   assign w_tck_en = (r_state != ST_IDLE);

   nios2os_vjtag_host_tckgen #(
      .TCK_DIV (TCK_DIV)
   ) u_tckgen (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_tck_en),
      .o_tck   (vji_tck),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_accept    = cmd_valid & r_cmd_ready;
   assign w_done      = (r_state == ST_RTI) & w_fall;
   assign w_sdr_rise  = (r_state == ST_SDR) & w_rise;
   assign w_shift_nxt = w_sdr_rise ? {vji_tdo, r_shift[DR_WIDTH-1:1]} : r_shift;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // IDLE with busy set is the one-clk gap between accept and UIR.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (r_busy) w_state_nxt = ST_UIR;
         ST_UIR:  if (w_fall) w_state_nxt = r_ir_only ? ST_RTI : ST_CDR;
         ST_CDR:  if (w_fall) w_state_nxt = ST_SDR;
         ST_SDR:  if (w_fall && (r_bitcnt == '0)) w_state_nxt = ST_UDR;
         ST_UDR:  if (w_fall) w_state_nxt = ST_RTI;
         ST_RTI:  if (w_fall) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_dr    <= '0;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_ir_only   <= 1'b0;
         r_ir        <= '0;
         r_tdi       <= 1'b0;
         r_uir       <= 1'b0;
         r_cdr       <= 1'b0;
         r_sdr       <= 1'b0;
         r_udr       <= 1'b0;
         r_rti       <= 1'b1;
      end else begin
         r_rsp_valid <= w_done;
         r_tdi       <= (w_state_nxt == ST_SDR) ? w_shift_nxt[0] : 1'b0;
         r_uir       <= (w_state_nxt == ST_UIR);
         r_cdr       <= (w_state_nxt == ST_CDR);
         r_sdr       <= (w_state_nxt == ST_SDR);
         r_udr       <= (w_state_nxt == ST_UDR);
         r_rti       <= (w_state_nxt == ST_RTI) || (w_state_nxt == ST_IDLE);
         if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_ir        <= cmd_ir;
            r_shift     <= cmd_dr;
            r_ir_only   <= cmd_ir_only;
            r_bitcnt    <= BW'(DR_WIDTH);
         end else begin
            r_shift <= w_shift_nxt;
            if (w_sdr_rise) r_bitcnt <= r_bitcnt - BW'(1);
            if (w_done) begin
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               if (!r_ir_only) r_rsp_dr <= r_shift;
            end
         end
      end
   end

`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
   logic [DR_WIDTH-1:0] r_expect;
   logic [DR_WIDTH-1:0] r_mask;
   logic                r_mismatch;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_expect   <= '0;
         r_mask     <= '0;
         r_mismatch <= 1'b0;
      end else begin
         if (w_accept) begin
            r_expect <= cmd_expect;
            r_mask   <= cmd_mask;
         end
         r_mismatch <= w_done && !r_ir_only && (|((r_shift ^ r_expect) & r_mask));
      end
   end

   assign rsp_mismatch = r_mismatch;
`endif

   assign cmd_ready   = r_cmd_ready;
   assign busy        = r_busy;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_dr      = r_rsp_dr;
   assign vji_tdi     = r_tdi;
   assign vji_ir_in   = r_ir;
   assign vji_uir     = r_uir;
   assign vji_cdr     = r_cdr;
   assign vji_sdr     = r_sdr;
   assign vji_udr     = r_udr;
   assign vji_rti     = r_rti;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nios2os_vjtag_host.sv
// Bench for nios2os_vjtag_host: one instance with TCK_DIV=1 (index 0) and one with TCK_DIV=4 (index 1).
module tb_nios2os_vjtag_host;
   import nios2os_vjtag_pkg::*;

   localparam int DW = 38;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         cmd_valid, cmd_ready, cmd_ir_only, rsp_valid, busy;
   logic [1:0]         tck, tdi, tdo, uir, cdr, sdr, udr, rti;
   logic [1:0][IW-1:0] cmd_ir, ir_in;
   logic [1:0][DW-1:0] cmd_dr, rsp_dr;
   logic [1:0][2:0]    dbg_state;
`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
   logic [1:0][DW-1:0] cmd_expect, cmd_mask;
   logic [1:0]         rsp_mismatch;
`endif

   for (genvar g = 0; g < 2; g++) begin : g_dut
      nios2os_vjtag_host #(
         .DR_WIDTH (DW),
         .IR_WIDTH (IW),
         .TCK_DIV  ((g == 0) ? 1 : 4)
      ) u_dut (
         .clk          (clk),
         .reset_n      (reset_n),
         .cmd_valid    (cmd_valid[g]),
         .cmd_ready    (cmd_ready[g]),
         .cmd_ir       (cmd_ir[g]),
         .cmd_dr       (cmd_dr[g]),
         .cmd_ir_only  (cmd_ir_only[g]),
         .rsp_valid    (rsp_valid[g]),
         .rsp_dr       (rsp_dr[g]),
         .busy         (busy[g]),
         .vji_tck      (tck[g]),
         .vji_tdi      (tdi[g]),
         .vji_tdo      (tdo[g]),
         .vji_ir_in    (ir_in[g]),
         .vji_uir      (uir[g]),
         .vji_cdr      (cdr[g]),
         .vji_sdr      (sdr[g]),
         .vji_udr      (udr[g]),
         .vji_rti      (rti[g]),
`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
         .cmd_expect   (cmd_expect[g]),
         .cmd_mask     (cmd_mask[g]),
         .rsp_mismatch (rsp_mismatch[g]),
`endif
         .o_dbg_state  (dbg_state[g])
      );
   end

   // tdo source per instance: 0 = loopback of tdi, 1 = constant one, 2 = random bit per clk
   int         tdo_sel[2];
   logic [1:0] tdo_src;
   assign tdo[0] = (tdo_sel[0] == 0) ? tdi[0] : tdo_src[0];
   assign tdo[1] = (tdo_sel[1] == 0) ? tdi[1] : tdo_src[1];

   int                 n_uir[2], n_cdr[2], n_udr[2], n_sdr[2], n_rise[2], rti_run[2], rti_last[2];
   logic [1:0][DW-1:0] cap_tdo, cap_tdi;
   logic [1:0]         tck_prev, tdi_prev, tdo_prev;

   initial begin
      tck_prev = '0; tdi_prev = '0; tdo_prev = '0; tdo_src = '0;
      cap_tdo = '0; cap_tdi = '0;
      for (int d = 0; d < 2; d++) begin
         n_uir[d] = 0; n_cdr[d] = 0; n_udr[d] = 0; n_sdr[d] = 0;
         n_rise[d] = 0; rti_run[d] = 0; rti_last[d] = 0;
      end
   end

   // Monitor: records the tdi/tdo bits present at every tck rise in SDR and flag durations.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (tck[d] && !tck_prev[d] && sdr[d]) begin
            cap_tdo[d] = {tdo_prev[d], cap_tdo[d][DW-1:1]};
            cap_tdi[d] = {tdi_prev[d], cap_tdi[d][DW-1:1]};
            n_rise[d]++;
         end
         n_uir[d] += int'(uir[d]);
         n_cdr[d] += int'(cdr[d]);
         n_udr[d] += int'(udr[d]);
         n_sdr[d] += int'(sdr[d]);
         if (rsp_valid[d]) rti_last[d] = rti_run[d];
         if (rti[d] && busy[d]) rti_run[d]++;
         else rti_run[d] = 0;
         tck_prev[d] = tck[d];
         tdi_prev[d] = tdi[d];
         tdo_src[d]  = (tdo_sel[d] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         tdo_prev[d] = (tdo_sel[d] == 0) ? tdi[d] : tdo_src[d];
      end
   end

   int              n_tests = 0;
   int              n_fail  = 0;
   logic [DW-1:0]   exp_q[$];
   logic [1:0][DW-1:0] model_rsp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int d, input string tag);
      chk($sformatf("%s_flags%0d", tag, d),
          {tck[d], tdi[d], ir_in[d], uir[d], cdr[d], sdr[d], udr[d], rti[d], cmd_ready[d], busy[d], rsp_valid[d]},
          {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      chk($sformatf("%s_rsp_dr%0d", tag, d), rsp_dr[d], 0);
   endtask

   task automatic wait_rsp(input int d, output int lat);
      lat = 0;
      while (rsp_valid[d] !== 1'b1 && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_cmd(input int d, input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic io,
                         output logic mm_o);
      int k, lat, b_uir, b_cdr, b_udr, b_sdr, b_rise;
      logic [DW-1:0] exp_dr, obs_dr;
      logic mm_exp;
      k = (d == 0) ? 1 : 4;
      mm_o = 1'b0;
      mm_exp = 1'b0;
      @(negedge clk);
      b_uir = n_uir[d]; b_cdr = n_cdr[d]; b_udr = n_udr[d]; b_sdr = n_sdr[d]; b_rise = n_rise[d];
      chk($sformatf("ready_idle%0d", d), cmd_ready[d], 1);
      cmd_ir[d] = ir; cmd_dr[d] = dr; cmd_ir_only[d] = io; cmd_valid[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid[d] = 1'b0;
      cmd_dr[d] = {$urandom, $urandom};
      chk($sformatf("busy_after_accept%0d", d), {busy[d], cmd_ready[d]}, 2'b10);
      wait_rsp(d, lat);
      chk($sformatf("latency%0d_io%0d", d, io), lat, io ? (4 * k + 1) : (2 * k * (DW + 4) + 1));
      chk($sformatf("ir_in%0d", d), ir_in[d], ir);
      chk($sformatf("idle_at_rsp%0d", d), {busy[d], cmd_ready[d], tck[d], tdi[d]}, 4'b0100);
      obs_dr = rsp_dr[d];
`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
      mm_o = rsp_mismatch[d];
`endif
      @(negedge clk);
      chk($sformatf("rsp_pulse%0d", d), rsp_valid[d], 0);
      if (io) exp_dr = model_rsp[d];
      else if (tdo_sel[d] == 0) exp_dr = dr;
      else if (tdo_sel[d] == 1) exp_dr = '1;
      else exp_dr = cap_tdo[d];
      if (!io) model_rsp[d] = exp_dr;
      exp_q.push_back(exp_dr);
      chk($sformatf("rsp_dr%0d", d), obs_dr, exp_q.pop_front());
      if (!io) chk($sformatf("tdi_bits%0d", d), cap_tdi[d], dr);
      chk($sformatf("sdr_rises%0d", d), n_rise[d] - b_rise, io ? 0 : DW);
      chk($sformatf("uir_len%0d", d), n_uir[d] - b_uir, 2 * k);
      chk($sformatf("cdr_len%0d", d), n_cdr[d] - b_cdr, io ? 0 : 2 * k);
      chk($sformatf("udr_len%0d", d), n_udr[d] - b_udr, io ? 0 : 2 * k);
      chk($sformatf("sdr_len%0d", d), n_sdr[d] - b_sdr, io ? 0 : 2 * k * DW);
      chk($sformatf("rti_len%0d", d), rti_last[d], 2 * k);
`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
      if (!io) mm_exp = |((exp_dr ^ cmd_expect[d]) & cmd_mask[d]);
      chk($sformatf("mismatch%0d", d), mm_o, mm_exp);
      chk($sformatf("mismatch_clear%0d", d), rsp_mismatch[d], 0);
`endif
   endtask

   initial begin
      logic          mm;
      logic [DW-1:0] dr_a, dr_b, bit5;
      int            lat, d, guard, n_rsp;
      logic          io;

      cmd_valid = '0; cmd_ir_only = '0; cmd_ir = '0; cmd_dr = '0;
      model_rsp = '0;
      tdo_sel[0] = 0; tdo_sel[1] = 0;
`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
      cmd_expect = '0; cmd_mask = '0;
`endif
      repeat (3) @(negedge clk);
      chk_reset(0, "reset");
      chk_reset(1, "reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset(1, "post_reset");

      // Loopback, TCK_DIV=1
      do_cmd(0, IR_OCIMEM, 38'h2A_5555_AAAA, 1'b0, mm);

      // Constant tdo=1, TCK_DIV=4
      tdo_sel[1] = 1;
      do_cmd(1, IR_TRACEMEM, '0, 1'b0, mm);

      // IR-only keeps the previous capture
      do_cmd(1, IR_TRACECTRL, {$urandom, $urandom}, 1'b1, mm);

      // Random tdo streams and random commands
      tdo_sel[0] = 2; tdo_sel[1] = 2;
      for (int i = 0; i < 6; i++) begin
         d  = (i < 4) ? 0 : 1;
         io = ($urandom_range(0, 3) == 0);
         do_cmd(d, IW'($urandom_range(0, 3)), {$urandom, $urandom}, io, mm);
      end

      // Back-to-back with cmd_valid held high throughout
      tdo_sel[0] = 0;
      dr_a = {$urandom, $urandom};
      dr_b = ~dr_a;
      @(negedge clk);
      exp_q.push_back(dr_a);
      exp_q.push_back(dr_b);
      cmd_ir[0] = IR_TRACEMEM; cmd_dr[0] = dr_a; cmd_ir_only[0] = 1'b0; cmd_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_ir[0] = IR_BREAK; cmd_dr[0] = dr_b;
      chk("b2b_busy_ignores", cmd_ready[0], 0);
      wait_rsp(0, lat);
      chk("b2b_lat_a", lat, 85);
      chk("b2b_rsp_a", rsp_dr[0], exp_q.pop_front());
      chk("b2b_ready_in_rsp", cmd_ready[0], 1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      chk("b2b_accept_b", {busy[0], cmd_ready[0]}, 2'b10);
      wait_rsp(0, lat);
      chk("b2b_lat_b", lat, 85);
      chk("b2b_rsp_b", rsp_dr[0], exp_q.pop_front());
      chk("b2b_ir_b", ir_in[0], IR_BREAK);
      model_rsp[0] = dr_b;
      @(negedge clk);
      chk("b2b_single_pulse", rsp_valid[0], 0);

`ifdef NIOS2OS_VJTAG_HOST_CHECK_EN
      bit5 = DW'(1) << 5;
      dr_a = 38'h15_0F0F_3C3C;
      cmd_expect[0] = dr_a; cmd_mask[0] = '1;
      do_cmd(0, IR_OCIMEM, dr_a, 1'b0, mm);
      chk("chk_match", mm, 0);
      cmd_expect[0] = dr_a ^ bit5;
      do_cmd(0, IR_OCIMEM, dr_a, 1'b0, mm);
      chk("chk_flip5", mm, 1);
      cmd_mask[0] = ~bit5;
      do_cmd(0, IR_OCIMEM, dr_a, 1'b0, mm);
      chk("chk_flip5_masked", mm, 0);
      cmd_mask[0] = '1;
      do_cmd(0, IR_OCIMEM, dr_a, 1'b1, mm);
      chk("chk_ir_only", mm, 0);
`endif

      // Asynchronous reset in the middle of an SDR scan
      tdo_sel[1] = 2;
      @(negedge clk);
      cmd_ir[1] = IR_BREAK; cmd_dr[1] = {$urandom, $urandom}; cmd_ir_only[1] = 1'b0; cmd_valid[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid[1] = 1'b0;
      guard = 0;
      while (sdr[1] !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("sdr_reached", sdr[1], 1);
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk_reset(1, "mid_sdr_reset");
      chk_reset(0, "mid_sdr_reset");
      @(negedge clk);
      reset_n = 1'b1;
      model_rsp = '0;
      n_rsp = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n_rsp += int'(rsp_valid[1]);
      end
      chk("no_rsp_after_abort", n_rsp, 0);
      chk_reset(1, "after_abort");

      // Link is usable again after the abort
      do_cmd(1, IR_OCIMEM, {$urandom, $urandom}, 1'b0, mm);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
